// File: rtl/adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adder_nbit                                                |
// | Purpose  : Combinational WIDTH-bit adder with carry in and carry out |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule
`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipelined_adder_nbit                                      |
// | Purpose  : NUM_STAGES-deep ripple-chunk adder, valid/ready handshake |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pipelined_adder_nbit #(
    parameter int NUM_BITS   = 16,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int C = NUM_BITS / NUM_STAGES;

    if (NUM_STAGES < 1 || NUM_STAGES > NUM_BITS || (NUM_BITS % NUM_STAGES) != 0) begin : g_bad_config
        $error("pipelined_adder_nbit: NUM_STAGES must be in 1..NUM_BITS and divide NUM_BITS");
    end

    logic [NUM_STAGES-1:0] stage_valid;
    logic [NUM_STAGES-1:0] advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int SUM_W = (k + 1) * C;

        logic             valid_q;
        logic             valid_d;
        logic             carry_q;
        logic             carry_d;
        logic [SUM_W-1:0] sum_q;
        logic [SUM_W-1:0] sum_d;
        logic [SUM_W-1:0] sum_next;
        logic             src_valid;
        logic             src_carry;
        logic [C-1:0]     src_a;
        logic [C-1:0]     src_b;
        logic [C-1:0]     chunk_sum;
        logic             chunk_carry;

        // A stage moves when it, or any stage after it, holds a bubble.
        assign stage_valid[k] = valid_q;
        assign advance[k]     = out_ready | ~(&stage_valid[NUM_STAGES-1:k]);

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_carry = carry_in;
            assign src_a     = a[C-1:0];
            assign src_b     = b[C-1:0];
            assign sum_next  = chunk_sum;
        end else begin : g_body
            assign src_valid = g_stage[k-1].valid_q;
            assign src_carry = g_stage[k-1].carry_q;
            assign src_a     = g_stage[k-1].g_skew.skew_a_q[C-1:0];
            assign src_b     = g_stage[k-1].g_skew.skew_b_q[C-1:0];
            assign sum_next  = {chunk_sum, g_stage[k-1].sum_q};
        end

        adder_nbit #(
            .WIDTH(C)
        ) u_chunk (
            .a         (src_a),
            .b         (src_b),
            .carry_in  (src_carry),
            .sum       (chunk_sum),
            .carry_out (chunk_carry)
        );

        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (advance[k]) begin
                valid_d = src_valid;
                carry_d = chunk_carry;
                sum_d   = sum_next;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        // Operand bits above this chunk travel alongside, low chunk first.
        if (k < NUM_STAGES - 1) begin : g_skew
            localparam int SKEW_W = NUM_BITS - SUM_W;

            logic [SKEW_W-1:0] skew_a_q;
            logic [SKEW_W-1:0] skew_a_d;
            logic [SKEW_W-1:0] skew_b_q;
            logic [SKEW_W-1:0] skew_b_d;
            logic [SKEW_W-1:0] skew_a_src;
            logic [SKEW_W-1:0] skew_b_src;

            if (k == 0) begin : g_from_port
                assign skew_a_src = a[NUM_BITS-1:C];
                assign skew_b_src = b[NUM_BITS-1:C];
            end else begin : g_from_stage
                assign skew_a_src = g_stage[k-1].g_skew.skew_a_q[SKEW_W+C-1:C];
                assign skew_b_src = g_stage[k-1].g_skew.skew_b_q[SKEW_W+C-1:C];
            end

            always_comb begin
                skew_a_d = skew_a_q;
                skew_b_d = skew_b_q;
                if (advance[k]) begin
                    skew_a_d = skew_a_src;
                    skew_b_d = skew_b_src;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    skew_a_q <= '0;
                    skew_b_q <= '0;
                end else begin
                    skew_a_q <= skew_a_d;
                    skew_b_q <= skew_b_d;
                end
            end
        end
    end

    assign in_ready  = ~rst & advance[0];
    assign out_valid = stage_valid[NUM_STAGES-1];
    assign sum       = g_stage[NUM_STAGES-1].sum_q;
    assign overflow  = g_stage[NUM_STAGES-1].carry_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipelined_adder_nbit                                   |
// | Purpose  : Self-checking bench for 4-, 1- and 16-stage builds        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pipelined_adder_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  rdy;
    logic [2:0]  ovld;
    logic [2:0]  ovf;
    logic [15:0] sum_o [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_check = 1'b0;

    // Per-build scoreboard: expected {overflow, sum} and acceptance cycle.
    logic [16:0] exp_val [3][4096];
    int          exp_cyc [3][4096];
    int          head [3];
    int          tail [3];

    always #5 clk = ~clk;

    pipelined_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(cin), .in_valid(in_valid),
        .in_ready(rdy[0]), .sum(sum_o[0]), .overflow(ovf[0]), .out_valid(ovld[0]),
        .out_ready(out_ready)
    );

    pipelined_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(cin), .in_valid(in_valid),
        .in_ready(rdy[1]), .sum(sum_o[1]), .overflow(ovf[1]), .out_valid(ovld[1]),
        .out_ready(out_ready)
    );

    pipelined_adder_nbit #(.NUM_BITS(16), .NUM_STAGES(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(cin), .in_valid(in_valid),
        .in_ready(rdy[2]), .sum(sum_o[2]), .overflow(ovf[2]), .out_valid(ovld[2]),
        .out_ready(out_ready)
    );

    function automatic int stg(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s stages=%0d cycle=%0d observed=%0h expected=%0h", tag, stg(d), cyc, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; observe, update model, advance.
    task automatic tick();
        #1;
        for (int d = 0; d < 3; d++) begin
            int s;
            int occ;
            s   = stg(d);
            occ = tail[d] - head[d];
            check("in_ready", d, 32'(rdy[d]), 32'(!rst && (out_ready || occ < s)));
            if (occ == 0) begin
                check("out_valid_idle", d, 32'(ovld[d]), 32'(0));
            end else begin
                if (lat_check)
                    check("out_valid_latency", d, 32'(ovld[d]),
                          32'((cyc - exp_cyc[d][head[d] % 4096]) >= s));
                if (ovld[d] === 1'b1)
                    check("result", d, 32'({ovf[d], sum_o[d]}), 32'(exp_val[d][head[d] % 4096]));
            end
            if (ovld[d] === 1'b1 && out_ready && occ > 0) head[d]++;
            if (in_valid && rdy[d] === 1'b1 && !rst) begin
                exp_val[d][tail[d] % 4096] = {1'b0, a} + {1'b0, b} + 17'(cin);
                exp_cyc[d][tail[d] % 4096] = cyc;
                tail[d]++;
            end
            if (rst) head[d] = tail[d];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_random();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((tail[0] != head[0] || tail[1] != head[1] || tail[2] != head[2]) && guard < 100) begin
            tick();
            guard++;
        end
        for (int d = 0; d < 3; d++)
            check("drain_empty", d, 32'(tail[d] - head[d]), 32'(0));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            head[d] = 0;
            tail[d] = 0;
        end
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_out_valid", d, 32'(ovld[d]), 32'(0));
            check("reset_sum", d, 32'(sum_o[d]), 32'(0));
            check("reset_overflow", d, 32'(ovf[d]), 32'(0));
        end
        tick();
        rst       = 1'b0;
        lat_check = 1'b1;
        tick();

        // Full-width ripple: 0xFFFF + 0x0001.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        drain();

        // Carry crossing a chunk boundary: 0x00FF + 0 + 1.
        a = 16'h00FF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
        tick();
        drain();

        // Eight back-to-back transactions.
        for (int i = 0; i < 8; i++) begin
            drive_random();
            in_valid = 1'b1;
            tick();
        end
        drain();

        // Downstream stall of six cycles in the middle of a stream.
        lat_check = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_random();
            in_valid  = 1'b1;
            out_ready = !(i >= 4 && i < 10);
            tick();
        end
        drain();
        lat_check = 1'b1;

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            drive_random();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();

        // Long random stream at full throughput.
        for (int i = 0; i < 1000; i++) begin
            drive_random();
            in_valid = 1'b1;
            tick();
        end
        drain();

        // Random handshake on both sides.
        lat_check = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive_random();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder_nbit.md
PIPELINED_ADDER_NBIT -- requirements
Module: pipelined_adder_nbit

Interface
REQ-001 The block SHALL take parameter NUM_BITS, default 16: operand and sum width.
REQ-002 The block SHALL take parameter NUM_STAGES, default 4: pipeline depth, in 1..NUM_BITS; NUM_BITS mod NUM_STAGES SHALL be 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port a, input, NUM_BITS bits: operand A.
REQ-006 The block SHALL have port b, input, NUM_BITS bits: operand B.
REQ-007 The block SHALL have port carry_in, input, 1 bit: carry into bit 0.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a, b and carry_in are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-010 The block SHALL have port sum, output, NUM_BITS bits: result, (a+b+carry_in) mod 2^NUM_BITS.
REQ-011 The block SHALL have port overflow, output, 1 bit: carry out of bit NUM_BITS-1.
REQ-012 The block SHALL have port out_valid, output, 1 bit: sum and overflow are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-014 A transaction SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge; it SHALL be delivered when out_valid and out_ready are both 1.
REQ-015 Chunk width SHALL be C = NUM_BITS/NUM_STAGES; stage k (0..NUM_STAGES-1) SHALL add bits [k*C +: C] of a and b plus the carry registered by stage k-1 (stage 0 uses carry_in).
REQ-016 Each stage SHALL register: its valid flag, the sum bits produced so far, the chunk carry-out, and the not-yet-added upper operand bits (skew registers).
REQ-017 With out_ready held at 1, latency from acceptance to out_valid SHALL be exactly NUM_STAGES cycles, at a throughput of one transaction per cycle.
REQ-018 Stage k SHALL advance when valid[k]=0 or stage k+1 advances; the last stage SHALL advance when out_ready=1 or out_valid=0.
REQ-019 in_ready SHALL be the stage-0 advance condition and SHALL NOT depend combinationally on in_valid.
REQ-020 While out_valid=1 and out_ready=0, sum, overflow and out_valid SHALL hold stable, and no accepted transaction SHALL be lost or duplicated.
REQ-021 Bubbles SHALL collapse: an empty stage SHALL accept from the stage before it even when downstream stages are stalled.
REQ-022 Results SHALL emerge in acceptance order; a and b SHALL only be sampled at acceptance.
REQ-023 The carry SHALL propagate across every chunk boundary; an all-ones operand plus carry_in=1 SHALL ripple through all stages.
REQ-024 When NUM_STAGES=1, the block SHALL act as a registered adder with one-cycle latency and the same handshake.

Reset
REQ-025 When rst=1 at a clk edge, the block SHALL clear every valid flag, clear all data, carry and skew registers, and drive out_valid=0, sum=0 and overflow=0.
REQ-026 While rst=1, in_ready SHALL be 0; it SHALL become 1 on the first cycle after rst deasserts.
REQ-027 A reset asserted mid-stream SHALL discard every in-flight transaction with no partial output.

Structure
REQ-028 Each stage's chunk addition SHALL use the existing adder_nbit sub-module with parameter C, instantiated NUM_STAGES times via generate.
REQ-029 No shared package SHALL be required; C SHALL be a localparam, and the divisibility check SHALL be an elaboration-time assertion.
REQ-030 The block SHALL contain only valid/skew/carry pipeline registers and no other state machine.

Verification
REQ-031 The bench SHALL cover: NUM_BITS=16, NUM_STAGES=4, a=0xFFFF, b=0x0001, cin=0 -> exactly 4 cycles later sum=0x0000, overflow=1, out_valid=1.
REQ-032 The bench SHALL cover: a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, overflow=0 (cross-chunk carry).
REQ-033 The bench SHALL cover: 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles, in order, matching a golden model.
REQ-034 The bench SHALL cover: out_ready=0 for 6 cycles during a stream -> in_ready drops once all 4 stages are full, outputs hold, and the full sequence is delivered after release with no loss.
REQ-035 The bench SHALL cover: rst pulsed with 3 transactions in flight -> out_valid=0 the next cycle, none of the 3 ever appears, and in_ready=1 after deassertion.
REQ-036 The bench SHALL cover: NUM_STAGES=1 and NUM_STAGES=16 builds running 1000 random vectors -> all match the golden model, with latency 1 and 16 respectively.
